// File: rtl/lfsr_pkg.sv
// Shared definitions for the 12-bit LFSR generator/checker pair:
// word width, checker state encoding and the next-state function.
package lfsr_pkg;

   localparam int LFSR_W = 12;

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } chk_state_t;

   // Taps 11/8/5/0, one-bit left shift, feedback enters bit 0.
   function automatic logic [LFSR_W-1:0] lfsr12_next(input logic [LFSR_W-1:0] d);
      return {d[10:0], d[11] ^ d[8] ^ d[5] ^ d[0]};
   endfunction

endpackage

// File: rtl/lfsr_chk_sat_cnt.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Synchronous clear takes priority over increment.
module sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/lfsr_chk.sv
// Self-synchronising checker for the 12-bit LFSR word stream: acquires lock
// from the data, then flywheels its own prediction and counts bad words.
module lfsr_chk
   import lfsr_pkg::*;
#(
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 3,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              clr,
   input  logic              in_valid,
   input  logic [LFSR_W-1:0] in_data,
   output logic              locked,
   output logic              err,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  word_cnt,
   output chk_state_t        state_dbg
);

   // in_valid is a one-way strobe with no back-pressure: a word is consumed on
   // every rising edge where in_valid=1, and nothing advances otherwise.

   localparam int RUN_W  = $clog2(LOCK_CNT + 1);
   localparam int MISS_W = $clog2(LOSS_CNT + 1);
   localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CNT - 1);
   localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_CNT - 1);

   chk_state_t        state_q, state_d;
   logic [LFSR_W-1:0] ref_q, ref_d;
   logic              have_ref_q, have_ref_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic [LFSR_W-1:0] pred_q, pred_d;
   logic [MISS_W-1:0] miss_q, miss_d;
   logic              err_q, err_d;
   logic              err_inc;
   logic              word_inc;
   logic              search_match;
   logic              locked_miss;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_SEARCH;
         ref_q      <= '0;
         have_ref_q <= 1'b0;
         run_q      <= '0;
         pred_q     <= '0;
         miss_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ref_q      <= ref_d;
         have_ref_q <= have_ref_d;
         run_q      <= run_d;
         pred_q     <= pred_d;
         miss_q     <= miss_d;
         err_q      <= err_d;
      end
   end

   // The all-zero lock-up word can never seed or extend a run.
   assign search_match = have_ref_q && (in_data == lfsr12_next(ref_q)) && (in_data != '0);
   assign locked_miss  = (in_data != pred_q);

   always_comb begin
      state_d    = state_q;
      ref_d      = ref_q;
      have_ref_d = have_ref_q;
      run_d      = run_q;
      pred_d     = pred_q;
      miss_d     = miss_q;
      err_d      = 1'b0;
      err_inc    = 1'b0;
      word_inc   = 1'b0;
      if (clr) begin
         state_d    = ST_SEARCH;
         have_ref_d = 1'b0;
         run_d      = '0;
         miss_d     = '0;
      end else if (in_valid) begin
         case (state_q)
            ST_SEARCH: begin
               ref_d      = in_data;
               have_ref_d = 1'b1;
               if (search_match) begin
                  run_d = run_q + RUN_W'(1);
                  if (run_q == RUN_LAST) begin
                     state_d = ST_LOCKED;
                     pred_d  = lfsr12_next(in_data);
                     miss_d  = '0;
                  end
               end else begin
                  run_d = '0;
               end
            end
            ST_LOCKED: begin
               // Flywheel: the prediction advances from itself, never from in_data.
               pred_d   = lfsr12_next(pred_q);
               word_inc = 1'b1;
               if (locked_miss) begin
                  err_d   = 1'b1;
                  err_inc = 1'b1;
                  if (miss_q == MISS_LAST) begin
                     state_d    = ST_SEARCH;
                     run_d      = '0;
                     ref_d      = in_data;
                     have_ref_d = 1'b1;
                     miss_d     = '0;
                  end else begin
                     miss_d = miss_q + MISS_W'(1);
                  end
               end else begin
                  miss_d = '0;
               end
            end
            default: state_d = ST_SEARCH;
         endcase
      end
   end

   sat_cnt #(.W(CNT_W)) u_err_cnt (
      .clk    (clk),
      .resetn (resetn),
      .clr    (clr),
      .inc    (err_inc),
      .cnt    (err_cnt)
   );

   sat_cnt #(.W(CNT_W)) u_word_cnt (
      .clk    (clk),
      .resetn (resetn),
      .clr    (clr),
      .inc    (word_inc),
      .cnt    (word_cnt)
   );

   assign locked    = (state_q == ST_LOCKED);
   assign err       = err_q;
   assign state_dbg = state_q;

endmodule

// File: doc/lfsr_chk.md
# lfsr_chk

Self-synchronising checker for the 12-bit LFSR word stream (taps 11, 8, 5, 0; one-bit left shift per step, feedback into bit 0). It sits directly downstream of the LFSR generator and consumes its parallel output one word per valid cycle. It acquires lock from the incoming data, then flywheels its own prediction, flags and counts mismatching words, and declares loss of lock after repeated errors.

## Interface
- `LOCK_CNT`, default 4: consecutive valid transitions needed to lock (≥1).
- `LOSS_CNT`, default 3: consecutive mismatches in LOCKED that drop lock (≥1).
- `CNT_W`, default 16: width of the saturating counters.

- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear of counters and lock state.
- `in_valid`  in  1  `in_data` carries a new word this cycle.
- `in_data`  in  12  word from the generator.
- `locked`  out  1  checker is locked.
- `err`  out  1  one-cycle pulse: last checked word mismatched.
- `err_cnt`  out  CNT_W  saturating count of mismatched words.
- `word_cnt`  out  CNT_W  saturating count of words checked while LOCKED.

## Operation
- The next-state function is `nxt(d) = {d[10:0], d[11]^d[8]^d[5]^d[0]}`.
- There are two states, SEARCH and LOCKED. Internal registers:
  - `ref[11:0]` and `have_ref`, the last word seen in SEARCH.
  - `run`, the match run length.
  - `pred[11:0]`, the predicted next word.
  - `miss`, the consecutive miss count.
- Nothing advances when `in_valid=0`. No register changes and `err` is 0.
- SEARCH behaviour on `in_valid`:
  - A match is `have_ref && in_data==nxt(ref) && in_data!=0`.
  - On a match, `run++`. Otherwise `run=0`.
  - In all cases, `ref<=in_data` and `have_ref<=1`.
  - When a match brings `run` to LOCK_CNT, go to LOCKED, set `pred<=nxt(in_data)`, and set `miss<=0`.
  - Mismatches in SEARCH are never counted and never pulse `err`.
- LOCKED behaviour on `in_valid`:
  - Compare `in_data` against `pred`, then set `pred<=nxt(pred)` (flywheel; the received data is never reloaded).
  - Every checked word increments `word_cnt`.
  - On a mismatch: `err<=1`, `err_cnt++`, `miss++`.
  - On a match: `miss<=0`.
  - When a mismatch brings `miss` to LOSS_CNT, go to SEARCH with `run=0`, `ref<=in_data`, `have_ref<=1`.
- An all-zero word (the lock-up state) never counts as a match in SEARCH. In LOCKED it is compared against `pred` like any other word.
- Both counters saturate at all-ones and never wrap.
- `clr` takes priority over `in_valid` in the same cycle. It causes:
  - state to SEARCH,
  - `have_ref`, `run` and `miss` to 0,
  - both counters to 0,
  - `err` to 0.
- Async reset (`resetn=0`) clears the same registers as `clr`, plus `ref` and `pred` to 0. Reset can be applied in any state, including mid-LOCKED, and takes effect immediately.

## Timing
- All outputs are registered. Reset values: `locked=0`, `err=0`, `err_cnt=0`, `word_cnt=0`.
- `locked` rises on the clock edge that samples the LOCK_CNT-th matching word, so it is visible in the following cycle. It falls on the edge that samples the LOSS_CNT-th consecutive miss.
- The earliest lock takes LOCK_CNT+1 valid words after reset or clr.
- `err` and the counter updates appear one cycle after the sampled word, and `err` lasts exactly one cycle per bad word.
- No combinational path exists from inputs to outputs.

## Structure
- Shared package `lfsr_pkg`:
  - function `lfsr12_next` (taps 11/8/5/0), reused by the generator,
  - state encoding constants `ST_SEARCH` and `ST_LOCKED`,
  - `LFSR_W=12`.
- One natural sub-module, `sat_cnt` (parameterised width; `inc` and `clr` inputs; async active-low reset). It is instantiated twice, for `err_cnt` and `word_cnt`.
- The FSM, comparator, and `run`/`miss` counters stay in `lfsr_chk`.

## Test plan
- **Reset:** hold `resetn=0` for 3 cycles. Required: `locked=0`, `err=0`, `err_cnt=0`, `word_cnt=0`.
- **Acquire:** feed 0x001, 0x003, 0x007, 0x00F, 0x01F on consecutive valid cycles. Required: `locked=1` in the cycle after 0x01F is sampled, and `err_cnt=0`.
- **Single error:** while locked, send 0x03F, then 0x07F in place of 0x07E, then 0x0FD. Required:
  - one `err` pulse,
  - `err_cnt=1`,
  - `locked` stays 1,
  - 0x0FD matches (the flywheel held).
- **Loss:** while locked, send 3 consecutive wrong words. Required: `err_cnt` goes +3 and `locked` drops after the third word. Resuming a correct stream relocks after LOCK_CNT matches.
- **Stalls and lock-up:**
  - Locked stream with `in_valid` gaps of 1–5 cycles: no errors, and `word_cnt` equals the number of valid words.
  - A stream of all-zero words: never locks.
- **Corners:**
  - `CNT_W=4` with 20 errors: `err_cnt` holds at 0xF.
  - `clr` together with a bad word: counters 0, `err=0`, SEARCH.
  - `resetn` pulsed low mid-LOCKED: all outputs return to reset values asynchronously.
